// File: rtl/reg_bus_router_if.sv
// reg_bus_router_if: register-bus bundle between the UART bridge, the router
// and the three target register files (RISC core, FPGA fabric, debugger).
// The slave modport is the router's view; the master modport is the
// surrounding environment (bridge plus targets).
interface reg_bus_router_if;
  // bridge side
  logic [7:0]  reg_addr;
  logic [31:0] reg_wr_data;
  logic        reg_wr_en;
  logic        reg_rd_en;
  logic        risc_rd_wr_cmd;
  logic        fpga_rd_wr_cmd;
  logic        debugger_rd_wr_cmd;
  logic [31:0] reg_rd_data;
  logic        reg_rd_done;
  logic        router_busy;
  // target side
  logic [7:0]  tgt_addr;
  logic [31:0] tgt_wr_data;
  logic [2:0]  tgt_wr_en;
  logic [2:0]  tgt_rd_en;
  logic [31:0] tgt_rd_data_risc;
  logic [31:0] tgt_rd_data_fpga;
  logic [31:0] tgt_rd_data_dbg;
  logic [2:0]  tgt_ack;
  // status counters
  logic [7:0]  timeout_cnt;
  logic [7:0]  decode_err_cnt;
  logic [7:0]  drop_cnt;

  modport slave (
    input  reg_addr, reg_wr_data, reg_wr_en, reg_rd_en,
    input  risc_rd_wr_cmd, fpga_rd_wr_cmd, debugger_rd_wr_cmd,
    input  tgt_rd_data_risc, tgt_rd_data_fpga, tgt_rd_data_dbg, tgt_ack,
    output reg_rd_data, reg_rd_done, router_busy,
    output tgt_addr, tgt_wr_data, tgt_wr_en, tgt_rd_en,
    output timeout_cnt, decode_err_cnt, drop_cnt
  );

  modport master (
    output reg_addr, reg_wr_data, reg_wr_en, reg_rd_en,
    output risc_rd_wr_cmd, fpga_rd_wr_cmd, debugger_rd_wr_cmd,
    output tgt_rd_data_risc, tgt_rd_data_fpga, tgt_rd_data_dbg, tgt_ack,
    input  reg_rd_data, reg_rd_done, router_busy,
    input  tgt_addr, tgt_wr_data, tgt_wr_en, tgt_rd_en,
    input  timeout_cnt, decode_err_cnt, drop_cnt
  );
endinterface

// File: rtl/reg_bus_router.sv
// reg_bus_router: routes bridge register accesses to the RISC core, FPGA
// fabric or debugger, with a one-entry pending slot, ack timeout and a
// guaranteed single reg_rd_done per read (target data or ERR_DATA).
// Optional feature macro: REG_BUS_ROUTER_WR_ACK_EN -- when defined, writes
// wait for the target ack (with timeout) like reads; otherwise writes are
// posted and tgt_ack is only consulted for reads.
module reg_bus_router #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
  input logic            core_clk,
  input logic            core_rst,
  reg_bus_router_if.slave bus
);

  localparam int unsigned TIMER_W = 16;
  localparam int unsigned CNT_W   = 8;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, RESP} state_t;

  // One latched access; tgt is one-hot, all-zero means decode error.
  typedef struct packed {
    logic        wr;
    logic [2:0]  tgt;
    logic [7:0]  addr;
    logic [31:0] data;
  } txn_t;

  state_t             state_q, state_d;
  txn_t               cur_q, cur_d;
  txn_t               pend_q, pend_d;
  logic               pend_vld_q, pend_vld_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [31:0]        rd_data_q, rd_data_d;
  logic               rd_done_q, rd_done_d;
  logic               busy_q, busy_d;
  logic [2:0]         wr_en_q, wr_en_d;
  logic [2:0]         rd_en_q, rd_en_d;
  logic [CNT_W-1:0]   timeout_cnt_q, timeout_cnt_d;
  logic [CNT_W-1:0]   decode_cnt_q, decode_cnt_d;
  logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;

  logic [2:0]  new_tgt;
  txn_t        wr_txn;
  txn_t        rd_txn;
  logic [31:0] sel_data;
  logic        q_wr;
  logic        q_rd;
  logic        slot_ok;
  logic [1:0]  drops;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c,
                                               input logic [1:0] n);
    logic [CNT_W:0] s;
    s = {1'b0, c} + (CNT_W+1)'(n);
    return (s > (CNT_W+1)'(255)) ? CNT_W'(255) : s[CNT_W-1:0];
  endfunction

  // Strobe-cycle decode: debugger > FPGA > RISC.
  assign new_tgt = bus.debugger_rd_wr_cmd ? 3'b100 :
                   bus.fpga_rd_wr_cmd     ? 3'b010 :
                   bus.risc_rd_wr_cmd     ? 3'b001 : 3'b000;

  assign wr_txn = {1'b1, new_tgt, bus.reg_addr, bus.reg_wr_data};
  assign rd_txn = {1'b0, new_tgt, bus.reg_addr, bus.reg_wr_data};

  // Read data of the target owning the current transaction.
  assign sel_data = cur_q.tgt[2] ? bus.tgt_rd_data_dbg  :
                    cur_q.tgt[1] ? bus.tgt_rd_data_fpga : bus.tgt_rd_data_risc;

  // State and output registers.
  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) begin
      state_q       <= IDLE;
      cur_q         <= '0;
      pend_q        <= '0;
      pend_vld_q    <= 1'b0;
      timer_q       <= '0;
      rd_data_q     <= '0;
      rd_done_q     <= 1'b0;
      busy_q        <= 1'b0;
      wr_en_q       <= '0;
      rd_en_q       <= '0;
      timeout_cnt_q <= '0;
      decode_cnt_q  <= '0;
      drop_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      cur_q         <= cur_d;
      pend_q        <= pend_d;
      pend_vld_q    <= pend_vld_d;
      timer_q       <= timer_d;
      rd_data_q     <= rd_data_d;
      rd_done_q     <= rd_done_d;
      busy_q        <= busy_d;
      wr_en_q       <= wr_en_d;
      rd_en_q       <= rd_en_d;
      timeout_cnt_q <= timeout_cnt_d;
      decode_cnt_q  <= decode_cnt_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  // Next-state, pending-slot and registered-output logic.
  always_comb begin
    state_d       = state_q;
    cur_d         = cur_q;
    pend_d        = pend_q;
    // In IDLE a full slot is always consumed this cycle.
    pend_vld_d    = (state_q == IDLE) ? 1'b0 : pend_vld_q;
    timer_d       = timer_q;
    rd_data_d     = rd_data_q;
    rd_done_d     = 1'b0;
    wr_en_d       = '0;
    rd_en_d       = '0;
    timeout_cnt_d = timeout_cnt_q;
    decode_cnt_d  = decode_cnt_q;
    drop_cnt_d    = drop_cnt_q;
    slot_ok       = (state_q == IDLE) || !pend_vld_q;
    drops         = 2'd0;
    q_wr          = bus.reg_wr_en;
    q_rd          = bus.reg_rd_en;

    case (state_q)
      IDLE: begin
        if (pend_vld_q || bus.reg_wr_en || bus.reg_rd_en) begin
          if (pend_vld_q) begin
            cur_d = pend_q;
          end else if (bus.reg_wr_en) begin
            cur_d = wr_txn;
            q_wr  = 1'b0;
          end else begin
            cur_d = rd_txn;
            q_rd  = 1'b0;
          end
          wr_en_d = cur_d.wr ? cur_d.tgt : 3'b000;
          rd_en_d = cur_d.wr ? 3'b000 : cur_d.tgt;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        timer_d = '0;
        if (cur_q.tgt == 3'b000) begin
          decode_cnt_d = sat_add(decode_cnt_q, 2'd1);
          if (cur_q.wr) begin
            state_d = IDLE;
          end else begin
            state_d   = RESP;
            rd_data_d = ERR_DATA;
            rd_done_d = 1'b1;
          end
        end else if (cur_q.wr) begin
`ifdef REG_BUS_ROUTER_WR_ACK_EN
          state_d = WAIT_ACK;
`else
          state_d = IDLE;
`endif
        end else begin
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        timer_d = timer_q + TIMER_W'(1);
        if ((bus.tgt_ack & cur_q.tgt) != 3'b000) begin
          if (cur_q.wr) begin
            state_d = IDLE;
          end else begin
            state_d   = RESP;
            rd_data_d = sel_data;
            rd_done_d = 1'b1;
          end
        end else if (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_cnt_d = sat_add(timeout_cnt_q, 2'd1);
          if (cur_q.wr) begin
            state_d = IDLE;
          end else begin
            state_d   = RESP;
            rd_data_d = ERR_DATA;
            rd_done_d = 1'b1;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Strobes not started this cycle go to the slot (write first) or drop.
    if (q_wr) begin
      if (slot_ok) begin
        pend_d     = wr_txn;
        pend_vld_d = 1'b1;
        slot_ok    = 1'b0;
      end else begin
        drops = drops + 2'd1;
      end
    end
    if (q_rd) begin
      if (slot_ok) begin
        pend_d     = rd_txn;
        pend_vld_d = 1'b1;
        slot_ok    = 1'b0;
      end else begin
        drops = drops + 2'd1;
      end
    end
    drop_cnt_d = sat_add(drop_cnt_q, drops);

    busy_d = (state_d != IDLE) || pend_vld_d;
  end

  assign bus.reg_rd_data    = rd_data_q;
  assign bus.reg_rd_done    = rd_done_q;
  assign bus.router_busy    = busy_q;
  assign bus.tgt_addr       = cur_q.addr;
  assign bus.tgt_wr_data    = cur_q.data;
  assign bus.tgt_wr_en      = wr_en_q;
  assign bus.tgt_rd_en      = rd_en_q;
  assign bus.timeout_cnt    = timeout_cnt_q;
  assign bus.decode_err_cnt = decode_cnt_q;
  assign bus.drop_cnt       = drop_cnt_q;

endmodule

// File: tb/tb_reg_bus_router.sv
// tb_reg_bus_router: directed plus randomized bench for reg_bus_router.
// Expected results come from transaction-level timing rules (strobe at
// offset 0, ack offset, timeout length) rather than a cycle model.
module tb_reg_bus_router;

  localparam int T = 8;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;
`ifdef REG_BUS_ROUTER_WR_ACK_EN
  localparam bit WR_ACK = 1'b1;
`else
  localparam bit WR_ACK = 1'b0;
`endif

  logic core_clk = 1'b0;
  logic core_rst;

  int checks = 0;
  int errors = 0;

  int          m_to;
  int          m_dec;
  int          m_drop;
  logic [31:0] m_last_rd;

  reg_bus_router_if bus();

  reg_bus_router #(.TIMEOUT_CYCLES(T), .ERR_DATA(ERR)) dut (
    .core_clk (core_clk),
    .core_rst (core_rst),
    .bus      (bus)
  );

  always #5 core_clk = ~core_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  task automatic step();
    @(posedge core_clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.reg_addr           = '0;
    bus.reg_wr_data        = '0;
    bus.reg_wr_en          = 1'b0;
    bus.reg_rd_en          = 1'b0;
    bus.risc_rd_wr_cmd     = 1'b0;
    bus.fpga_rd_wr_cmd     = 1'b0;
    bus.debugger_rd_wr_cmd = 1'b0;
    bus.tgt_rd_data_risc   = '0;
    bus.tgt_rd_data_fpga   = '0;
    bus.tgt_rd_data_dbg    = '0;
    bus.tgt_ack            = '0;
  endtask

  task automatic check_status(input string tag);
    check({tag, ".timeout_cnt"}, 32'(bus.timeout_cnt), 32'(m_to));
    check({tag, ".decode_err_cnt"}, 32'(bus.decode_err_cnt), 32'(m_dec));
    check({tag, ".drop_cnt"}, 32'(bus.drop_cnt), 32'(m_drop));
    check({tag, ".rd_data_hold"}, bus.reg_rd_data, m_last_rd);
    check({tag, ".busy_idle"}, 32'(bus.router_busy), 32'd0);
  endtask

  // One isolated access; sel is {dbg, fpga, risc}; ack_at is the cycle
  // offset of the single tgt_ack pulse (out of range means no ack).
  task automatic run_txn(input string tag, input bit wr, input logic [2:0] sel,
                         input logic [7:0] addr, input logic [31:0] wdata,
                         input int ack_at, input logic [2:0] ack_mask,
                         input logic [31:0] dr, input logic [31:0] df,
                         input logic [31:0] dd);
    logic [2:0]  exp_tgt;
    logic [31:0] exp_data;
    int          exp_done;
    int          exp_busy;
    bit          ok_ack;
    int          done_n;
    int          done_off;
    int          last_busy;
    int          en_n;
    logic [2:0]  en_wr;
    logic [2:0]  en_rd;
    logic [7:0]  got_addr;
    logic [31:0] got_wd;
    logic [31:0] got_data;

    exp_tgt  = sel[2] ? 3'b100 : sel[1] ? 3'b010 : sel[0] ? 3'b001 : 3'b000;
    exp_data = (exp_tgt == 3'b100) ? dd : (exp_tgt == 3'b010) ? df : dr;
    ok_ack   = (exp_tgt != 3'b000) && (ack_at >= 2) && (ack_at <= T + 1) &&
               ((ack_mask & exp_tgt) != 3'b000);
    exp_done = -1;
    if (exp_tgt == 3'b000) begin
      m_dec    = sat(m_dec);
      exp_data = ERR;
      exp_done = wr ? -1 : 2;
      exp_busy = wr ? 1 : 2;
    end else if (wr && !WR_ACK) begin
      exp_busy = 1;
    end else if (ok_ack) begin
      exp_done = wr ? -1 : ack_at + 1;
      exp_busy = wr ? ack_at : ack_at + 1;
    end else begin
      m_to     = sat(m_to);
      exp_data = ERR;
      exp_done = wr ? -1 : T + 2;
      exp_busy = wr ? T + 1 : T + 2;
    end
    if (!wr) m_last_rd = exp_data;

    done_n = 0; done_off = -1; last_busy = -1; en_n = 0;
    en_wr = '0; en_rd = '0; got_addr = '0; got_wd = '0; got_data = '0;
    for (int off = 0; off <= T + 4; off++) begin
      step();
      if (bus.reg_rd_done) begin
        done_n++;
        done_off = off;
        got_data = bus.reg_rd_data;
      end
      if (bus.router_busy) last_busy = off;
      if ((bus.tgt_wr_en | bus.tgt_rd_en) != 3'b000) begin
        en_n++;
        if (off == 1) begin
          en_wr    = bus.tgt_wr_en;
          en_rd    = bus.tgt_rd_en;
          got_addr = bus.tgt_addr;
          got_wd   = bus.tgt_wr_data;
        end
      end
      bus.reg_wr_en          = (off == 0) && wr;
      bus.reg_rd_en          = (off == 0) && !wr;
      bus.reg_addr           = (off == 0) ? addr : 8'($urandom);
      bus.reg_wr_data        = (off == 0) ? wdata : $urandom;
      bus.risc_rd_wr_cmd     = (off == 0) ? sel[0] : 1'($urandom);
      bus.fpga_rd_wr_cmd     = (off == 0) ? sel[1] : 1'($urandom);
      bus.debugger_rd_wr_cmd = (off == 0) ? sel[2] : 1'($urandom);
      bus.tgt_ack            = (off == ack_at) ? ack_mask : 3'b000;
      bus.tgt_rd_data_risc   = (off == ack_at) ? dr : $urandom;
      bus.tgt_rd_data_fpga   = (off == ack_at) ? df : $urandom;
      bus.tgt_rd_data_dbg    = (off == ack_at) ? dd : $urandom;
    end
    idle_inputs();

    check({tag, ".tgt_wr_en"}, 32'(en_wr), wr ? 32'(exp_tgt) : 32'd0);
    check({tag, ".tgt_rd_en"}, 32'(en_rd), wr ? 32'd0 : 32'(exp_tgt));
    check({tag, ".strobe_cycles"}, 32'(en_n), (exp_tgt != 3'b000) ? 32'd1 : 32'd0);
    if (exp_tgt != 3'b000) begin
      check({tag, ".tgt_addr"}, 32'(got_addr), 32'(addr));
      if (wr) check({tag, ".tgt_wr_data"}, got_wd, wdata);
    end
    check({tag, ".done_count"}, 32'(done_n), wr ? 32'd0 : 32'd1);
    if (!wr) begin
      check({tag, ".done_cycle"}, 32'(done_off), 32'(exp_done));
      check({tag, ".rd_data"}, got_data, exp_data);
    end
    check({tag, ".busy_last"}, 32'(last_busy), 32'(exp_busy));
    check_status(tag);
  endtask

  // All selects high, write+read together, then a third strobe while full.
  task automatic collision_test();
    logic [2:0]  ack_next;
    bit          ack_next_rd;
    logic [31:0] ack_data;
    logic [31:0] exp_rd;
    logic [31:0] got;
    logic [2:0]  first_wr;
    logic [7:0]  first_addr;
    logic [31:0] first_wd;
    logic [2:0]  rd_seen;
    int          done_n;
    int          wr_n;
    int          rd_n;

    ack_next = '0; ack_next_rd = 1'b0; exp_rd = '0; got = '0;
    first_wr = '0; first_addr = '0; first_wd = '0; rd_seen = '0;
    done_n = 0; wr_n = 0; rd_n = 0;
    for (int off = 0; off < 30; off++) begin
      step();
      if (bus.reg_rd_done) begin
        done_n++;
        got = bus.reg_rd_data;
      end
      if (bus.tgt_wr_en != 3'b000) begin
        wr_n++;
        if (off == 1) begin
          first_wr   = bus.tgt_wr_en;
          first_addr = bus.tgt_addr;
          first_wd   = bus.tgt_wr_data;
        end
      end
      if (bus.tgt_rd_en != 3'b000) begin
        rd_n++;
        rd_seen = bus.tgt_rd_en;
      end
      idle_inputs();
      if (off == 0) begin
        bus.reg_wr_en          = 1'b1;
        bus.reg_rd_en          = 1'b1;
        bus.risc_rd_wr_cmd     = 1'b1;
        bus.fpga_rd_wr_cmd     = 1'b1;
        bus.debugger_rd_wr_cmd = 1'b1;
        bus.reg_addr           = 8'h33;
        bus.reg_wr_data        = 32'hA5A5_A5A5;
      end
      if (off == 1) begin
        bus.reg_rd_en      = 1'b1;
        bus.risc_rd_wr_cmd = 1'b1;
        bus.reg_addr       = 8'h44;
      end
      if (ack_next != 3'b000) begin
        ack_data             = $urandom;
        bus.tgt_ack          = ack_next;
        bus.tgt_rd_data_dbg  = ack_data;
        bus.tgt_rd_data_fpga = ~ack_data;
        bus.tgt_rd_data_risc = ack_data ^ 32'h5A5A_0F0F;
        if (ack_next_rd) exp_rd = ack_data;
      end
      ack_next    = bus.tgt_wr_en | bus.tgt_rd_en;
      ack_next_rd = (bus.tgt_rd_en != 3'b000);
    end
    idle_inputs();
    m_drop    = sat(m_drop);
    m_last_rd = exp_rd;

    check("coll.first_wr_en", 32'(first_wr), 32'h4);
    check("coll.tgt_addr", 32'(first_addr), 32'h33);
    check("coll.tgt_wr_data", first_wd, 32'hA5A5_A5A5);
    check("coll.wr_strobes", 32'(wr_n), 32'd1);
    check("coll.rd_strobes", 32'(rd_n), 32'd1);
    check("coll.rd_en", 32'(rd_seen), 32'h4);
    check("coll.done_count", 32'(done_n), 32'd1);
    check("coll.rd_data", got, exp_rd);
    check_status("coll");
  endtask

  // Reset while a read waits for its ack; no late completion afterwards.
  task automatic reset_test();
    int done_n;
    done_n = 0;
    step();
    bus.reg_rd_en      = 1'b1;
    bus.risc_rd_wr_cmd = 1'b1;
    bus.reg_addr       = 8'h55;
    step();
    idle_inputs();
    step();
    step();
    step();
    check("rst.busy_before", 32'(bus.router_busy), 32'd1);
    core_rst = 1'b1;
    #1;
    check("rst.busy", 32'(bus.router_busy), 32'd0);
    check("rst.rd_done", 32'(bus.reg_rd_done), 32'd0);
    check("rst.rd_data", bus.reg_rd_data, 32'd0);
    check("rst.tgt_addr", 32'(bus.tgt_addr), 32'd0);
    check("rst.tgt_en", 32'({bus.tgt_wr_en, bus.tgt_rd_en}), 32'd0);
    check("rst.counters", 32'({bus.timeout_cnt, bus.decode_err_cnt, bus.drop_cnt}), 32'd0);
    m_to = 0; m_dec = 0; m_drop = 0; m_last_rd = '0;
    step();
    core_rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (bus.reg_rd_done) done_n++;
      bus.tgt_ack          = (i % 2 == 0) ? 3'b001 : 3'b000;
      bus.tgt_rd_data_risc = $urandom;
    end
    idle_inputs();
    check("rst.no_done", 32'(done_n), 32'd0);
    check_status("rst");
  endtask

  initial begin
    m_to = 0; m_dec = 0; m_drop = 0; m_last_rd = '0;
    core_rst = 1'b1;
    idle_inputs();
    step();
    step();
    check("reset.rd_data", bus.reg_rd_data, 32'd0);
    check("reset.rd_done", 32'(bus.reg_rd_done), 32'd0);
    check("reset.busy", 32'(bus.router_busy), 32'd0);
    check("reset.tgt_addr", 32'(bus.tgt_addr), 32'd0);
    check("reset.tgt_wr_data", bus.tgt_wr_data, 32'd0);
    check("reset.tgt_en", 32'({bus.tgt_wr_en, bus.tgt_rd_en}), 32'd0);
    check("reset.counters", 32'({bus.timeout_cnt, bus.decode_err_cnt, bus.drop_cnt}), 32'd0);
    core_rst = 1'b0;
    step();

    run_txn("fpga_rd", 1'b0, 3'b010, 8'h10, 32'h0, 4, 3'b010,
            32'h1111_1111, 32'h1234_5678, 32'h2222_2222);
    run_txn("dbg_timeout", 1'b0, 3'b100, 8'h20, 32'h0, 99, 3'b000,
            32'h1, 32'h2, 32'h3);
    run_txn("dec_rd", 1'b0, 3'b000, 8'h30, 32'h0, 2, 3'b111,
            32'h4, 32'h5, 32'h6);
    run_txn("dec_wr", 1'b1, 3'b000, 8'h31, 32'h0BAD_F00D, 99, 3'b000,
            32'h7, 32'h8, 32'h9);
    run_txn("risc_wr_ack3", 1'b1, 3'b001, 8'h40, 32'hCAFE_0001, 3, 3'b001,
            32'hA, 32'hB, 32'hC);
    run_txn("min_latency", 1'b0, 3'b001, 8'h41, 32'h0, 2, 3'b001,
            32'h7777_0001, 32'hD, 32'hE);
    run_txn("ack_too_early", 1'b0, 3'b011, 8'h42, 32'h0, 1, 3'b010,
            32'hF, 32'h7777_0002, 32'h10);
    run_txn("ack_at_timeout", 1'b0, 3'b110, 8'h43, 32'h0, T + 1, 3'b100,
            32'h11, 32'h12, 32'h7777_0003);
    run_txn("ack_unselected", 1'b0, 3'b010, 8'h44, 32'h0, 3, 3'b101,
            32'h13, 32'h14, 32'h15);

    collision_test();
    reset_test();
    run_txn("after_reset", 1'b0, 3'b001, 8'h66, 32'h0, 2, 3'b001,
            32'h6666_0001, 32'h16, 32'h17);

    for (int n = 0; n < 30; n++) begin
      int          a;
      logic [2:0]  m;
      a = ($urandom_range(0, 4) == 0) ? 99 : int'($urandom_range(1, T + 3));
      m = 3'($urandom);
      run_txn("rand", 1'($urandom), 3'($urandom), 8'($urandom), $urandom,
              a, m, $urandom, $urandom, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_bus_router.md
# reg_bus_router

Routes the single register bus driven by the UART register bridge to one of three targets: RISC core, FPGA fabric registers, or debugger. Target choice comes from the bridge's command-class select lines. Each access is a timed transaction. A read always produces exactly one `reg_rd_done`, returning either target data or an error word, so the bridge's response FSM can never hang. The block sits between the UART bridge and the target register files.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1024: cycles to wait for a target ack before aborting; legal range 2..65535.
- `ERR_DATA`, default 32'hDEAD_BEEF: data returned on a timeout or decode-error read.

Ports:
- `core_clk`  in  1  sole clock.
- `core_rst`  in  1  asynchronous, active-high reset.
- `reg_addr`  in  8  access address from the bridge.
- `reg_wr_data`  in  32  write data.
- `reg_wr_en`  in  1  one-cycle write strobe.
- `reg_rd_en`  in  1  one-cycle read strobe.
- `risc_rd_wr_cmd`, `fpga_rd_wr_cmd`, `debugger_rd_wr_cmd`  in  1 each  target selects; level signals, sampled on the strobe cycle.
- `reg_rd_data`  out  32  read return data.
- `reg_rd_done`  out  1  one-cycle read completion.
- `router_busy`  out  1  high while a transaction is outstanding.
- `tgt_addr`  out  8  registered address shared by all targets.
- `tgt_wr_data`  out  32  registered write data shared by all targets.
- `tgt_wr_en`  out  3  one-hot write strobe; bit0 RISC, bit1 FPGA, bit2 debugger.
- `tgt_rd_en`  out  3  one-hot read strobe; same bit order.
- `tgt_rd_data_risc`, `tgt_rd_data_fpga`, `tgt_rd_data_dbg`  in  32 each  target read data, valid with the matching ack bit.
- `tgt_ack`  in  3  per-target one-cycle ack.
- `timeout_cnt`  out  8  saturating count of timed-out transactions.
- `decode_err_cnt`  out  8  saturating count of accesses with no target selected.
- `drop_cnt`  out  8  saturating count of strobes lost because the pending slot was full.

## Operation
- Reset values:
  - All outputs are 0.
  - FSM is in IDLE.
  - The pending slot is empty.
  - Counters are 0.
- Target decode on the strobe cycle:
  - Priority is debugger > FPGA > RISC.
  - If no select is high, the access is a decode error.
- FSM states: IDLE, ISSUE, WAIT_ACK, RESP.
- IDLE:
  - A write or read strobe, or a non-empty pending slot, latches addr, data, kind and target, then moves to ISSUE.
  - The pending slot has priority over a new strobe.
- ISSUE:
  - Pulses the selected `tgt_wr_en` or `tgt_rd_en` bit for one cycle.
  - Clears the timer and moves to WAIT_ACK.
  - Decode error, read: skip to RESP with `ERR_DATA`.
  - Decode error, write: return to IDLE with no target strobe.
  - Both decode-error cases increment `decode_err_cnt`.
- WAIT_ACK:
  - An ack on the selected bit ends the wait.
    - Read: capture that target's data and go to RESP.
    - Write: go to IDLE.
  - Ack bits for unselected targets are ignored.
  - Timer reaches `TIMEOUT_CYCLES - 1` with no ack: increment `timeout_cnt`.
    - Read: go to RESP with `ERR_DATA`.
    - Write: go to IDLE.
- RESP: drives `reg_rd_done` = 1 for one cycle with `reg_rd_data`, then returns to IDLE. `reg_rd_data` holds its value until the next RESP.
- Pending slot:
  - Holds one entry.
  - A strobe arriving while the FSM is not IDLE is stored there.
  - A further strobe while the slot is full is dropped and increments `drop_cnt`.
- Simultaneous `reg_wr_en` and `reg_rd_en` in IDLE: the write is serviced and the read goes to the pending slot.
- `router_busy` = (state != IDLE) | pending slot full.
- Reset mid-transaction: all state clears immediately; an outstanding read gets no `reg_rd_done`.
- Counters saturate at 255 and do not wrap.

## Timing
- A strobe at cycle N produces `tgt_*_en` at N+1 and WAIT_ACK from N+2.
- A read ack at cycle M produces `reg_rd_done` at M+1.
- Minimum read latency is 3 cycles from strobe to done; this needs the ack at N+2.
- Ack timing:
  - An ack at N+1, coincident with the strobe, is not accepted.
  - An ack on the same cycle the timeout fires counts as success.
- Decode-error read: `reg_rd_done` at N+2.
- Timeout read: `reg_rd_done` at N+2+`TIMEOUT_CYCLES`.

## Configuration
- `REG_BUS_ROUTER_WR_ACK_EN` defined:
  - Writes wait in WAIT_ACK for the target ack, with timeout, exactly as reads do.
- `REG_BUS_ROUTER_WR_ACK_EN` undefined:
  - Writes are posted: ISSUE goes directly to IDLE.
  - A write takes 2 cycles strobe-to-idle and never increments `timeout_cnt`.
  - `tgt_ack` is consulted only for reads.

## Test plan
- FPGA read: `fpga_rd_wr_cmd`=1, `reg_addr`=8'h10, `reg_rd_en` at N; ack bit1 with 32'h1234_5678 at N+4 -> `tgt_rd_en`=3'b010 at N+1; `reg_rd_done`=1 at N+5 with data 32'h1234_5678.
- Timeout: `TIMEOUT_CYCLES`=8, debugger read, no ack -> `reg_rd_done` at N+10 with 32'hDEAD_BEEF; `timeout_cnt`=1.
- Decode error: no select, read at N -> done at N+2 with 32'hDEAD_BEEF, `decode_err_cnt`=1, `tgt_rd_en` never asserted. Write with no select -> no target strobe, `decode_err_cnt`=2.
- Priority and collision: all selects high, write 32'hA5A5_A5A5 and read in the same cycle -> `tgt_wr_en`=3'b100 first; read to debugger follows from the pending slot; exactly one `reg_rd_done`. A third strobe while busy -> `drop_cnt`=1.
- Write ack, with and without macro: RISC write, ack at N+3. With the macro: busy until N+3 inclusive. Without the macro: busy falls after N+1 and the ack is ignored.
- Reset mid-read: assert `core_rst` in WAIT_ACK -> outputs 0 immediately; after release, no `reg_rd_done`; a new read completes normally.
